// File: rtl/inst_rom_ws_pkg.sv
// ============================================================================
// Module  : inst_rom_ws_pkg
// Brief   : Shared constants and FSM encodings for the wait-state instruction ROM.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package inst_rom_ws_pkg;

    localparam logic        RstEnable   = 1'b0;
    localparam logic        ChipEnable  = 1'b1;
    localparam logic        ChipDisable = 1'b0;
    localparam int          InstBusW    = 32;
    localparam logic [31:0] NopWord     = 32'h0000_0000;

    typedef enum logic [1:0] {
        ROM_IDLE = 2'd0,
        ROM_WAIT = 2'd1,
        ROM_RESP = 2'd2
    } rom_state_e;

endpackage

`default_nettype wire

// File: rtl/inst_rom_ws_wait_ctr.sv
// ============================================================================
// Module  : rom_wait_ctr
// Brief   : Loadable wait-state down-counter with zero detect.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module rom_wait_ctr
    import inst_rom_ws_pkg::*;
#(
    parameter int WAIT_CYCLES = 1
) (
    input  logic clk,
    input  logic rst,
    input  logic load_i,
    input  logic dec_i,
    output logic zero_o
);

    localparam logic [3:0] c_LOAD_VAL = 4'(WAIT_CYCLES - 1);

    logic [3:0] r_cnt;

    always_ff @(posedge clk or negedge rst) begin
        if (rst == RstEnable) begin
            r_cnt <= 4'd0;
        end else if (load_i) begin
            r_cnt <= c_LOAD_VAL;
        end else if (dec_i && (r_cnt != 4'd0)) begin
            r_cnt <= r_cnt - 4'd1;
        end
    end

    assign zero_o = (r_cnt == 4'd0);

endmodule

`default_nettype wire

// File: rtl/inst_rom_ws.sv
// ============================================================================
// Module  : inst_rom_ws
// Brief   : Word-addressed instruction ROM with wait states and a bench load port.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module inst_rom_ws
    import inst_rom_ws_pkg::*;
#(
    parameter int                DATA_W      = InstBusW,
    parameter int                ADDR_W      = 32,
    parameter int                DEPTH       = 1024,
    parameter int                WAIT_CYCLES = 0,
    parameter logic [DATA_W-1:0] NOP_WORD    = NopWord
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     ce_i,
    input  logic [ADDR_W-1:0]        addr_i,
    output logic [DATA_W-1:0]        data_o,
    output logic                     ready_o,
    output logic                     err_o,
    input  logic                     ld_we_i,
    input  logic [$clog2(DEPTH)-1:0] ld_addr_i,
    input  logic [DATA_W-1:0]        ld_data_i
);

    localparam int c_IDX_W = $clog2(DEPTH);

    logic [DATA_W-1:0] r_mem [DEPTH];
    rom_state_e        r_state;
    rom_state_e        w_state_nxt;
    logic [ADDR_W-1:0] r_addr;
    logic [DATA_W-1:0] r_data;
    logic              w_accept;
    logic              w_ctr_zero;
    logic              w_ld_en;
    logic [ADDR_W-1:0] w_fetch_addr;
    logic [ADDR_W-1:0] w_hi_bits;
    logic [c_IDX_W-1:0] w_idx;
    logic              w_oor;
    logic              w_misal;
    logic [DATA_W-1:0] w_rd_word;

    assign w_accept = (ce_i == ChipEnable) && (r_state != ROM_WAIT);
    assign w_ld_en  = ld_we_i && (rst != RstEnable);

    generate
        if (WAIT_CYCLES > 0) begin : g_wait_ctr
            rom_wait_ctr #(
                .WAIT_CYCLES (WAIT_CYCLES)
            ) u_wait_ctr (
                .clk    (clk),
                .rst    (rst),
                .load_i (w_accept),
                .dec_i  (r_state == ROM_WAIT),
                .zero_o (w_ctr_zero)
            );
        end else begin : g_no_wait_ctr
            assign w_ctr_zero = 1'b1;
        end
    endgenerate

    always_ff @(posedge clk or negedge rst) begin
        if (rst == RstEnable) begin
            r_state <= ROM_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        ready_o     = 1'b0;
        err_o       = 1'b0;
        case (r_state)
            ROM_IDLE, ROM_RESP: begin
                if (ce_i == ChipEnable) begin
                    w_state_nxt = (WAIT_CYCLES == 0) ? ROM_RESP : ROM_WAIT;
                end else begin
                    w_state_nxt = ROM_IDLE;
                end
            end
            ROM_WAIT: begin
                if (ce_i == ChipDisable) begin
                    w_state_nxt = ROM_IDLE;
                end else if (w_ctr_zero) begin
                    w_state_nxt = ROM_RESP;
                end
            end
            default: w_state_nxt = ROM_IDLE;
        endcase
        if (r_state == ROM_RESP) begin
            ready_o = 1'b1;
            err_o   = (r_addr[1:0] != 2'b00);
        end
    end

    // With zero wait states the RESP-producing edge is the accept edge, so
    // the live address is used there; otherwise the captured one.
    assign w_fetch_addr = (r_state == ROM_WAIT) ? r_addr : addr_i;
    assign w_hi_bits    = w_fetch_addr >> (c_IDX_W + 2);
    assign w_oor        = |w_hi_bits;
    assign w_misal      = (w_fetch_addr[1:0] != 2'b00);
    assign w_idx        = w_fetch_addr[c_IDX_W+1:2];

    always_comb begin
        w_rd_word = r_mem[w_idx];
        if (w_oor || w_misal) begin
            w_rd_word = NOP_WORD;
        end else if (w_ld_en && (ld_addr_i == w_idx)) begin
            w_rd_word = ld_data_i;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (rst == RstEnable) begin
            r_addr <= '0;
        end else if (w_accept) begin
            r_addr <= addr_i;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (rst == RstEnable) begin
            r_data <= '0;
        end else if (w_state_nxt == ROM_RESP) begin
            r_data <= w_rd_word;
        end else if ((r_state == ROM_IDLE) && (ce_i == ChipDisable)) begin
            r_data <= '0;
        end
    end

    always_ff @(posedge clk) begin
        if (w_ld_en) begin
            r_mem[ld_addr_i] <= ld_data_i;
        end
    end

    assign data_o = r_data;

endmodule

`default_nettype wire

// File: tb/tb_inst_rom_ws.sv
// ============================================================================
// Module  : tb_inst_rom_ws
// Brief   : Directed bench for inst_rom_ws at 0, 1 and 3 wait states.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_inst_rom_ws;

    localparam logic [31:0] c_NOP0 = 32'h0BAD_0000;

    logic        clk;
    logic        rst;
    logic        ld_we;
    logic [9:0]  ld_addr;
    logic [31:0] ld_data;

    logic        ce0, ce1, ce3;
    logic [31:0] addr0, addr1, addr3;
    logic [31:0] data0, data1, data3;
    logic        rdy0, rdy1, rdy3;
    logic        err0, err1, err3;

    int n_checks;
    int n_pass;

    logic [31:0] words [4];

    inst_rom_ws #(.WAIT_CYCLES(0), .NOP_WORD(c_NOP0)) u_dut0 (
        .clk(clk), .rst(rst), .ce_i(ce0), .addr_i(addr0),
        .data_o(data0), .ready_o(rdy0), .err_o(err0),
        .ld_we_i(ld_we), .ld_addr_i(ld_addr), .ld_data_i(ld_data)
    );

    inst_rom_ws #(.WAIT_CYCLES(1)) u_dut1 (
        .clk(clk), .rst(rst), .ce_i(ce1), .addr_i(addr1),
        .data_o(data1), .ready_o(rdy1), .err_o(err1),
        .ld_we_i(ld_we), .ld_addr_i(ld_addr), .ld_data_i(ld_data)
    );

    inst_rom_ws #(.WAIT_CYCLES(3)) u_dut3 (
        .clk(clk), .rst(rst), .ce_i(ce3), .addr_i(addr3),
        .data_o(data3), .ready_o(rdy3), .err_o(err3),
        .ld_we_i(ld_we), .ld_addr_i(ld_addr), .ld_data_i(ld_data)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %08h expected %08h", tag, got, exp);
        end
    endtask

    task automatic load_word(input logic [9:0] idx, input logic [31:0] val);
        @(negedge clk);
        ld_we   = 1'b1;
        ld_addr = idx;
        ld_data = val;
        @(posedge clk);
        #1;
        ld_we   = 1'b0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        n_checks = 0;
        n_pass   = 0;
        words[0] = 32'h3401_1100;
        words[1] = 32'h3402_0020;
        words[2] = 32'h3403_ff00;
        words[3] = 32'h3404_ffff;
        rst = 1'b1;
        ld_we = 1'b0; ld_addr = '0; ld_data = '0;
        ce0 = 1'b0; ce1 = 1'b0; ce3 = 1'b0;
        addr0 = '0; addr1 = '0; addr3 = '0;

        #2 rst = 1'b0;
        #98;
        check("reset_data", data0, 32'h0);
        check("reset_ready", {31'b0, rdy0}, 32'h0);
        check("reset_err", {31'b0, err0}, 32'h0);
        #95 rst = 1'b1;

        for (int i = 0; i < 4; i++) load_word(10'(i), words[i]);
        load_word(10'd1023, 32'h1234_5678);

        // Zero-wait stream of four words, then address boundaries
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            ce0   = 1'b1;
            addr0 = 32'(4 * i);
            tick();
            check($sformatf("stream_data%0d", i), data0, words[i]);
            check($sformatf("stream_ready%0d", i), {31'b0, rdy0}, 32'h1);
            check($sformatf("stream_err%0d", i), {31'b0, err0}, 32'h0);
        end
        @(negedge clk); addr0 = 32'h0000_0FFC; tick();
        check("top_word_data", data0, 32'h1234_5678);
        check("top_word_err", {31'b0, err0}, 32'h0);
        @(negedge clk); addr0 = 32'h0000_1000; tick();
        check("oor_data", data0, c_NOP0);
        check("oor_ready", {31'b0, rdy0}, 32'h1);
        check("oor_err", {31'b0, err0}, 32'h0);
        @(negedge clk); addr0 = 32'h0000_0002; tick();
        check("misal_data", data0, c_NOP0);
        check("misal_err", {31'b0, err0}, 32'h1);
        @(negedge clk); ce0 = 1'b0; tick();
        check("idle_ready", {31'b0, rdy0}, 32'h0);
        check("idle_err", {31'b0, err0}, 32'h0);
        tick();
        check("idle_data_zero", data0, 32'h0);

        // Three wait states; address change mid-wait must be ignored
        @(negedge clk); ce3 = 1'b1; addr3 = 32'd8; tick();
        check("w3_cyc1_ready", {31'b0, rdy3}, 32'h0);
        @(negedge clk); addr3 = 32'd4; tick();
        check("w3_cyc2_ready", {31'b0, rdy3}, 32'h0);
        tick();
        check("w3_cyc3_ready", {31'b0, rdy3}, 32'h0);
        tick();
        check("w3_cyc4_ready", {31'b0, rdy3}, 32'h1);
        check("w3_cyc4_data", data3, words[2]);
        @(negedge clk); ce3 = 1'b0; tick();
        check("w3_after_ready", {31'b0, rdy3}, 32'h0);

        // Asynchronous reset in the middle of a wait
        @(negedge clk); ce3 = 1'b1; addr3 = 32'd8; tick();
        check("rst_mid_hold_data", data3, words[2]);
        #2 rst = 1'b0;
        #1;
        check("rst_mid_data", data3, 32'h0);
        check("rst_mid_ready", {31'b0, rdy3}, 32'h0);
        check("rst_mid_err", {31'b0, err3}, 32'h0);
        @(negedge clk); ce3 = 1'b0; rst = 1'b1;

        // Abort: drop ce after one wait cycle, expect no response
        @(negedge clk); ce3 = 1'b1; addr3 = 32'd4; tick();
        @(negedge clk); ce3 = 1'b0; tick();
        check("abort_ready0", {31'b0, rdy3}, 32'h0);
        tick();
        check("abort_ready1", {31'b0, rdy3}, 32'h0);
        tick();
        check("abort_ready2", {31'b0, rdy3}, 32'h0);
        // From IDLE a fresh accept answers on the fourth cycle; memory survived reset
        @(negedge clk); ce3 = 1'b1; addr3 = 32'd12; tick();
        tick();
        tick();
        check("reaccept_cyc3_ready", {31'b0, rdy3}, 32'h0);
        tick();
        check("reaccept_ready", {31'b0, rdy3}, 32'h1);
        check("reaccept_data", data3, words[3]);
        @(negedge clk); ce3 = 1'b0;

        // Write-first collision on the RESP-producing edge
        @(negedge clk); ce1 = 1'b1; addr1 = 32'd4; tick();
        check("wf_wait_ready", {31'b0, rdy1}, 32'h0);
        @(negedge clk);
        ld_we = 1'b1; ld_addr = 10'd1; ld_data = 32'hDEAD_BEEF;
        tick();
        ld_we = 1'b0;
        check("wf_ready", {31'b0, rdy1}, 32'h1);
        check("wf_data", data1, 32'hDEAD_BEEF);
        check("wf_err", {31'b0, err1}, 32'h0);
        @(negedge clk); ce1 = 1'b0;
        tick();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

`default_nettype wire
